// File: rtl/motor_pulse_counter.sv
`timescale 1ns/1ps
// Hall/encoder pulse conditioner: synchroniser, glitch filter, signed edge counter, period timer, stall detect, snapshot port.
// Latency: pulse_in rising (first sampling edge) to edge_strobe is FILTER_CYCLES+3 clk edges; count/period update one cycle later.
// Backpressure: none on the pulse path; snapshot uses a four-phase snap_req/snap_ack level handshake.
//
// Ports:
//   clk, reset            system clock, synchronous active-high reset
//   pulse_in              raw asynchronous hall pulse
//   dir                   0 = count up, 1 = count down (sampled in the edge_strobe cycle)
//   snap_req / snap_ack   snapshot handshake; snap_count/snap_period/snap_valid hold the captured set
//   count, period         live signed position and last edge-to-edge period in clk cycles
//   period_valid          two edges seen since reset or stall recovery
//   stalled               no edge for STALL_CYCLES
//   edge_strobe           one-cycle pulse per filtered rising edge
//
// Optional feature: define PULSE_CLR_ON_SNAP_EN to clear count on every snapshot capture (delta mode).

module motor_pulse_counter #(
    parameter int COUNT_W       = 16,
    parameter int PERIOD_W      = 20,
    parameter int FILTER_CYCLES = 4,
    parameter int STALL_CYCLES  = 480000
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                pulse_in,
    input  logic                dir,
    input  logic                snap_req,
    output logic                snap_ack,
    output logic [COUNT_W-1:0]  snap_count,
    output logic [PERIOD_W-1:0] snap_period,
    output logic                snap_valid,
    output logic [COUNT_W-1:0]  count,
    output logic [PERIOD_W-1:0] period,
    output logic                period_valid,
    output logic                stalled,
    output logic                edge_strobe
);

    localparam int FCW = (FILTER_CYCLES > 1) ? $clog2(FILTER_CYCLES) : 1;
    localparam logic [FCW-1:0]      FILT_LAST = FCW'(FILTER_CYCLES - 1);
    localparam logic [PERIOD_W-1:0] PMAX      = '1;
    localparam logic [PERIOD_W-1:0] STALL_AT  = PERIOD_W'(STALL_CYCLES - 1);

    typedef enum logic {S_IDLE, S_ACK} snap_state_t;

    logic               sync1;
    logic               sync2;
    logic               filt;
    logic               filt_d;
    logic [FCW-1:0]     fcnt;
    logic [PERIOD_W-1:0] timer;
    logic               armed;
    logic [COUNT_W-1:0] step;
    logic               capture;
    snap_state_t        snap_state;

    // Two-flop synchroniser; pulse_in goes straight into the first flop.
    always_ff @(posedge clk) begin
        if (reset) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
        end else begin
            sync1 <= pulse_in;
            sync2 <= sync1;
        end
    end

    // The filtered level only follows the synchronised line after it has
    // disagreed for FILTER_CYCLES consecutive samples.
    always_ff @(posedge clk) begin
        if (reset) begin
            filt <= 1'b0;
            fcnt <= '0;
        end else if (sync2 == filt) begin
            fcnt <= '0;
        end else if (fcnt == FILT_LAST) begin
            filt <= ~filt;
            fcnt <= '0;
        end else begin
            fcnt <= fcnt + FCW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            filt_d      <= 1'b0;
            edge_strobe <= 1'b0;
        end else begin
            filt_d      <= filt;
            edge_strobe <= filt & ~filt_d;
        end
    end

    // All-ones is -1 in two's complement, so the down step is a plain add.
    assign step    = dir ? '1 : COUNT_W'(1);
    assign capture = (snap_state == S_IDLE) && snap_req;

    always_ff @(posedge clk) begin
        if (reset) begin
            count <= '0;
`ifdef PULSE_CLR_ON_SNAP_EN
        end else if (capture) begin
            // The snapshot takes the pre-edge value, so a coincident edge
            // becomes the first step of the new delta window.
            count <= edge_strobe ? step : '0;
`endif
        end else if (edge_strobe) begin
            count <= count + step;
        end
    end

    // Timer restarts on each strobe, so timer+1 at the next strobe is the
    // exact strobe-to-strobe distance. The first edge after reset or stall
    // only arms the measurement because the timer start point is unknown.
    always_ff @(posedge clk) begin
        if (reset) begin
            timer        <= '0;
            period       <= '0;
            period_valid <= 1'b0;
            armed        <= 1'b0;
            stalled      <= 1'b0;
        end else if (edge_strobe) begin
            timer   <= '0;
            stalled <= 1'b0;
            if (armed) begin
                period       <= (timer == PMAX) ? PMAX : timer + PERIOD_W'(1);
                period_valid <= 1'b1;
            end else begin
                armed <= 1'b1;
            end
        end else begin
            if (timer != PMAX) begin
                timer <= timer + PERIOD_W'(1);
            end
            if (!stalled && (timer == STALL_AT)) begin
                stalled      <= 1'b1;
                period_valid <= 1'b0;
                armed        <= 1'b0;
                period       <= PMAX;
            end
        end
    end

    // Snapshot handshake: capture once on request, hold until the requester
    // drops snap_req, then release snap_ack one cycle later.
    always_ff @(posedge clk) begin
        if (reset) begin
            snap_state  <= S_IDLE;
            snap_ack    <= 1'b0;
            snap_count  <= '0;
            snap_period <= '0;
            snap_valid  <= 1'b0;
        end else begin
            case (snap_state)
                S_IDLE: begin
                    if (snap_req) begin
                        snap_count  <= count;
                        snap_period <= period;
                        snap_valid  <= period_valid;
                        snap_ack    <= 1'b1;
                        snap_state  <= S_ACK;
                    end
                end
                S_ACK: begin
                    if (!snap_req) begin
                        snap_ack   <= 1'b0;
                        snap_state <= S_IDLE;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_motor_pulse_counter.sv
`timescale 1ns/1ps
module tb_motor_pulse_counter;

`ifdef PULSE_CLR_ON_SNAP_EN
    localparam bit DELTA = 1'b1;
`else
    localparam bit DELTA = 1'b0;
`endif

    logic clk = 1'b0;
    logic reset = 1'b0;

    // Instance A: default parameters.
    logic        a_pulse = 1'b0, a_dir = 1'b0, a_snap_req = 1'b0;
    logic        a_snap_ack, a_snap_valid, a_period_valid, a_stalled, a_edge;
    logic [15:0] a_snap_count, a_count;
    logic [19:0] a_snap_period, a_period;

    // Instance B: narrow counter, minimal filter, short stall window.
    logic        b_pulse = 1'b0, b_dir = 1'b0, b_snap_req = 1'b0;
    logic        b_snap_ack, b_snap_valid, b_period_valid, b_stalled, b_edge;
    logic [7:0]  b_snap_count, b_count;
    logic [19:0] b_snap_period, b_period;

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    logic [15:0] exp_q[$];
    logic [15:0] ma;

    motor_pulse_counter dut_a (
        .clk(clk), .reset(reset), .pulse_in(a_pulse), .dir(a_dir), .snap_req(a_snap_req),
        .snap_ack(a_snap_ack), .snap_count(a_snap_count), .snap_period(a_snap_period),
        .snap_valid(a_snap_valid), .count(a_count), .period(a_period),
        .period_valid(a_period_valid), .stalled(a_stalled), .edge_strobe(a_edge)
    );

    motor_pulse_counter #(.COUNT_W(8), .PERIOD_W(20), .FILTER_CYCLES(1), .STALL_CYCLES(100)) dut_b (
        .clk(clk), .reset(reset), .pulse_in(b_pulse), .dir(b_dir), .snap_req(b_snap_req),
        .snap_ack(b_snap_ack), .snap_count(b_snap_count), .snap_period(b_snap_period),
        .snap_valid(b_snap_valid), .count(b_count), .period(b_period),
        .period_valid(b_period_valid), .stalled(b_stalled), .edge_strobe(b_edge)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic do_reset();
        @(posedge clk); #1;
        reset = 1'b1; a_pulse = 1'b0; b_pulse = 1'b0; a_snap_req = 1'b0; b_snap_req = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        reset = 1'b0;
        ma = 16'h0;
        exp_q.delete();
    endtask

    // One pulse: high for hi sampling edges, low for the rest of hi+lo edges.
    // Optionally raises a_snap_req right after edge snap_k.
    task automatic drive_pulse(input bit on_b, input bit d, input int hi, input int lo, input int snap_k,
                               output int nstrobe, output int lat, output int strobe_cyc, output int ack_k);
        nstrobe = 0; lat = -1; strobe_cyc = -1; ack_k = -1;
        @(posedge clk); #1;
        if (on_b) begin b_dir = d; b_pulse = 1'b1; end
        else begin a_dir = d; a_pulse = 1'b1; end
        for (int k = 1; k <= hi + lo; k++) begin
            @(posedge clk); #1;
            if (k == hi) begin
                if (on_b) b_pulse = 1'b0;
                else a_pulse = 1'b0;
            end
            if (k == snap_k) a_snap_req = 1'b1;
            @(negedge clk);
            if ((on_b ? b_edge : a_edge) === 1'b1) begin
                nstrobe++;
                if (lat < 0) begin lat = k; strobe_cyc = cyc; end
            end
            if (a_snap_ack === 1'b1 && ack_k < 0) ack_k = k;
        end
    endtask

    task automatic test_reset();
        do_reset();
        @(negedge clk);
        checks++; if (a_count !== 16'h0) begin errors++; $display("FAIL reset_count got %h want 0000", a_count); end
        checks++; if (a_period !== 20'h0 || a_period_valid !== 1'b0) begin errors++; $display("FAIL reset_period got %h/%b want 00000/0", a_period, a_period_valid); end
        checks++; if (a_stalled !== 1'b0 || a_edge !== 1'b0) begin errors++; $display("FAIL reset_flags got stalled=%b strobe=%b want 0/0", a_stalled, a_edge); end
        checks++; if (a_snap_ack !== 1'b0 || a_snap_count !== 16'h0 || a_snap_period !== 20'h0 || a_snap_valid !== 1'b0) begin
            errors++; $display("FAIL reset_snap_a got ack=%b cnt=%h per=%h v=%b want all 0", a_snap_ack, a_snap_count, a_snap_period, a_snap_valid); end
        checks++; if (b_snap_ack !== 1'b0 || b_snap_count !== 8'h0 || b_snap_period !== 20'h0 || b_snap_valid !== 1'b0 || b_count !== 8'h0) begin
            errors++; $display("FAIL reset_b got ack=%b scnt=%h per=%h v=%b cnt=%h want all 0", b_snap_ack, b_snap_count, b_snap_period, b_snap_valid, b_count); end
    endtask

    task automatic test_glitch();
        int ns, lat, sc, ak;
        do_reset();
        exp_q.push_back(ma);
        drive_pulse(1'b0, 1'b0, 3, 20, 0, ns, lat, sc, ak);
        checks++; if (ns !== 0) begin errors++; $display("FAIL glitch_strobes got %0d want 0", ns); end
        checks++; if (a_count !== exp_q.pop_front()) begin errors++; $display("FAIL glitch_count got %h want 0000", a_count); end
        ma = ma + 16'd1; exp_q.push_back(ma);
        drive_pulse(1'b0, 1'b0, 20, 20, 0, ns, lat, sc, ak);
        checks++; if (ns !== 1 || lat !== 7) begin errors++; $display("FAIL edge_latency got strobes=%0d lat=%0d want 1/7", ns, lat); end
        checks++; if (a_count !== exp_q.pop_front()) begin errors++; $display("FAIL edge_count got %h want 0001", a_count); end
    endtask

    task automatic test_period();
        int ns, lat, sc, ak;
        logic [15:0] e;
        do_reset();
        for (int i = 1; i <= 12; i++) begin
            if (i <= 5) ma = ma + 16'd1; else ma = ma - 16'd1;
            exp_q.push_back(ma);
            drive_pulse(1'b0, (i > 5), 8, 991, 0, ns, lat, sc, ak);
            e = exp_q.pop_front();
            checks++; if (a_count !== e) begin errors++; $display("FAIL period_count[%0d] got %h want %h", i, a_count, e); end
            if (i == 1) begin
                checks++; if (a_period_valid !== 1'b0 || a_period !== 20'h0) begin errors++; $display("FAIL period_armed got %h/%b want 00000/0", a_period, a_period_valid); end
            end else begin
                checks++; if (a_period_valid !== 1'b1 || a_period !== 20'd1000) begin errors++; $display("FAIL period[%0d] got %0d/%b want 1000/1", i, a_period, a_period_valid); end
            end
        end
        checks++; if (a_count !== 16'hFFFE) begin errors++; $display("FAIL count_after_dir got %h want fffe", a_count); end
    endtask

    task automatic test_wrap();
        int ns, lat, sc, ak;
        do_reset();
        drive_pulse(1'b0, 1'b1, 6, 10, 0, ns, lat, sc, ak);
        checks++; if (a_count !== 16'hFFFF) begin errors++; $display("FAIL wrap_down16 got %h want ffff", a_count); end
        do_reset();
        for (int i = 0; i < 127; i++) drive_pulse(1'b1, 1'b0, 2, 3, 0, ns, lat, sc, ak);
        checks++; if (lat !== 4) begin errors++; $display("FAIL edge_latency_f1 got %0d want 4", lat); end
        checks++; if (b_count !== 8'h7F) begin errors++; $display("FAIL wrap_pre got %h want 7f", b_count); end
        drive_pulse(1'b1, 1'b0, 2, 3, 0, ns, lat, sc, ak);
        checks++; if (b_count !== 8'h80) begin errors++; $display("FAIL wrap_up got %h want 80", b_count); end
        do_reset();
        drive_pulse(1'b1, 1'b1, 2, 3, 0, ns, lat, sc, ak);
        checks++; if (b_count !== 8'hFF) begin errors++; $display("FAIL wrap_down8 got %h want ff", b_count); end
    endtask

    task automatic test_stall();
        int ns, lat, sc, ak, rise;
        do_reset();
        drive_pulse(1'b1, 1'b0, 2, 3, 0, ns, lat, sc, ak);
        drive_pulse(1'b1, 1'b0, 2, 3, 0, ns, lat, sc, ak);
        checks++; if (b_period !== 20'd6 || b_period_valid !== 1'b1 || b_stalled !== 1'b0) begin
            errors++; $display("FAIL prestall got per=%0d v=%b st=%b want 6/1/0", b_period, b_period_valid, b_stalled); end
        rise = -1;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (b_stalled === 1'b1) begin rise = cyc; break; end
        end
        checks++; if (rise - sc !== 101) begin errors++; $display("FAIL stall_time got %0d want 101 cycles after strobe", rise - sc); end
        checks++; if (b_period !== 20'hFFFFF || b_period_valid !== 1'b0) begin errors++; $display("FAIL stall_period got %h/%b want fffff/0", b_period, b_period_valid); end
        drive_pulse(1'b1, 1'b0, 2, 47, 0, ns, lat, sc, ak);
        checks++; if (b_stalled !== 1'b0 || b_period !== 20'hFFFFF || b_period_valid !== 1'b0) begin
            errors++; $display("FAIL rearm got st=%b per=%h v=%b want 0/fffff/0", b_stalled, b_period, b_period_valid); end
        drive_pulse(1'b1, 1'b0, 2, 3, 0, ns, lat, sc, ak);
        checks++; if (b_period !== 20'd50 || b_period_valid !== 1'b1) begin errors++; $display("FAIL recover_period got %0d/%b want 50/1", b_period, b_period_valid); end
    endtask

    task automatic test_snapshot();
        int ns, lat, sc, ak;
        logic [15:0] e;
        do_reset();
        for (int i = 0; i < 9; i++) begin
            ma = ma + 16'd1;
            drive_pulse(1'b0, 1'b0, 6, 9, 0, ns, lat, sc, ak);
        end
        checks++; if (a_count !== ma) begin errors++; $display("FAIL snap_pre_count got %h want %h", a_count, ma); end
        // snap_req rises in the strobe cycle of the 10th edge.
        exp_q.push_back(DELTA ? 16'd1 : ma + 16'd1);
        drive_pulse(1'b0, 1'b0, 6, 9, 7, ns, lat, sc, ak);
        checks++; if (ak !== 8) begin errors++; $display("FAIL snap_ack_timing got k=%0d want 8", ak); end
        checks++; if (a_snap_count !== 16'd9 || a_snap_period !== 20'd16 || a_snap_valid !== 1'b1) begin
            errors++; $display("FAIL snap_capture got %0d/%0d/%b want 9/16/1", a_snap_count, a_snap_period, a_snap_valid); end
        e = exp_q.pop_front();
        checks++; if (a_count !== e) begin errors++; $display("FAIL snap_edge_count got %h want %h", a_count, e); end
        exp_q.push_back(e + 16'd1);
        drive_pulse(1'b0, 1'b0, 6, 9, 0, ns, lat, sc, ak);
        e = exp_q.pop_front();
        checks++; if (a_count !== e) begin errors++; $display("FAIL hold_count got %h want %h", a_count, e); end
        checks++; if (a_snap_ack !== 1'b1 || a_snap_count !== 16'd9 || a_snap_period !== 20'd16) begin
            errors++; $display("FAIL snap_hold got ack=%b cnt=%0d per=%0d want 1/9/16", a_snap_ack, a_snap_count, a_snap_period); end
        @(posedge clk); #1; a_snap_req = 1'b0;
        @(negedge clk);
        checks++; if (a_snap_ack !== 1'b1) begin errors++; $display("FAIL ack_drop_early got %b want 1", a_snap_ack); end
        @(negedge clk);
        checks++; if (a_snap_ack !== 1'b0) begin errors++; $display("FAIL ack_drop got %b want 0", a_snap_ack); end
    endtask

    task automatic test_snap_no_edge();
        int ns, lat, sc, ak;
        bit ok;
        do_reset();
        for (int i = 0; i < 12; i++) drive_pulse(1'b0, 1'b0, 6, 9, 0, ns, lat, sc, ak);
        @(posedge clk); #1; a_snap_req = 1'b1;
        ok = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (a_snap_ack === 1'b1) begin ok = 1'b1; break; end
        end
        checks++; if (!ok) begin errors++; $display("FAIL snap_ack_timeout got ack=%b want 1", a_snap_ack); end
        checks++; if (a_snap_count !== 16'd12) begin errors++; $display("FAIL snap12 got %0d want 12", a_snap_count); end
        checks++; if (a_count !== (DELTA ? 16'd0 : 16'd12)) begin errors++; $display("FAIL snap_clear got %0d want %0d", a_count, DELTA ? 0 : 12); end
        @(posedge clk); #1; a_snap_req = 1'b0;
        repeat (3) @(negedge clk);
    endtask

    task automatic test_reset_in_ack();
        int ns, lat, sc, ak;
        bit ok;
        do_reset();
        drive_pulse(1'b0, 1'b0, 6, 9, 0, ns, lat, sc, ak);
        @(posedge clk); #1; a_snap_req = 1'b1;
        ok = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (a_snap_ack === 1'b1) begin ok = 1'b1; break; end
        end
        checks++; if (!ok || a_snap_count !== 16'd1) begin errors++; $display("FAIL pre_reset_ack got ack=%b cnt=%0d want 1/1", a_snap_ack, a_snap_count); end
        @(posedge clk); #1; reset = 1'b1; a_snap_req = 1'b0;
        @(posedge clk); #1; reset = 1'b0;
        @(negedge clk);
        checks++; if (a_snap_ack !== 1'b0 || a_count !== 16'h0 || a_snap_count !== 16'h0) begin
            errors++; $display("FAIL reset_in_ack got ack=%b cnt=%h scnt=%h want 0/0000/0000", a_snap_ack, a_count, a_snap_count); end
        @(posedge clk); #1; a_snap_req = 1'b1;
        @(posedge clk); @(negedge clk);
        checks++; if (a_snap_ack !== 1'b1) begin errors++; $display("FAIL idle_after_reset got ack=%b want 1", a_snap_ack); end
        @(posedge clk); #1; a_snap_req = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_glitch();
        test_period();
        test_wrap();
        test_stall();
        test_snapshot();
        test_snap_no_edge();
        test_reset_in_ack();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
